// File: rtl/keypad_entry_ctrl.sv
// Keypad front end for the two-operand decimal adder: debounce, single-shot press detect, entry FSM, BCD display word.
// Operands/result settle 1 cycle after o_key_event and o_disp_bcd 1 cycle later; no backpressure, one event per press.
module keypad_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int RELEASE_CYCLES  = 50000,
    parameter int MAX_DIGITS      = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_key_code,
    input  logic        i_key_valid,
    output logic        o_key_event,
    output logic [3:0]  o_key_last,
    output logic [1:0]  o_state,
    output logic [6:0]  o_operand_a,
    output logic [6:0]  o_operand_b,
    output logic [7:0]  o_result,
    output logic [15:0] o_disp_bcd
);
    localparam int PW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(RELEASE_CYCLES + 1);
    localparam logic [PW-1:0] PRESS_MAX = PW'(DEBOUNCE_CYCLES);
    localparam logic [RW-1:0] REL_MAX   = RW'(RELEASE_CYCLES);
    localparam logic [1:0]    DIG_MAX   = 2'(MAX_DIGITS);

    typedef enum logic [1:0] {
        ENTER_A  = 2'd0,
        ENTER_B  = 2'd1,
        SHOW_SUM = 2'd2
    } state_t;

    logic [3:0]    r_cand;
    logic [PW-1:0] r_press_cnt;
    logic [RW-1:0] r_rel_cnt;
    logic          r_armed;
    logic          r_key_event;
    logic [3:0]    r_key_last;
    state_t        r_state;
    logic [6:0]    r_op_a;
    logic [6:0]    r_op_b;
    logic [7:0]    r_result;
    logic [1:0]    r_digits;
    logic [15:0]   r_disp;

    logic [PW-1:0] w_press_nxt;
    logic [RW-1:0] w_rel_nxt;
    logic          w_accept;
    logic [6:0]    w_digit;
    logic          w_is_digit;
    logic          w_room;
    logic [7:0]    w_show;
    logic [3:0]    w_hund;
    logic [3:0]    w_tens;
    logic [3:0]    w_unit;

    // Low-valid cycles neither clear nor advance the press count: the scanner
    // drops key_valid while it visits other rows during a genuine hold.
    always_comb begin
        w_press_nxt = r_press_cnt;
        if (i_key_valid) begin
            if (i_key_code != r_cand)
                w_press_nxt = PW'(1);
            else if (r_press_cnt != PRESS_MAX)
                w_press_nxt = r_press_cnt + PW'(1);
        end
        w_rel_nxt = (r_rel_cnt == REL_MAX) ? r_rel_cnt : r_rel_cnt + RW'(1);
        w_accept  = i_key_valid && r_armed && (w_press_nxt == PRESS_MAX);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cand      <= 4'hF;
            r_press_cnt <= '0;
            r_rel_cnt   <= '0;
            r_armed     <= 1'b1;
            r_key_event <= 1'b0;
            r_key_last  <= 4'hF;
        end else begin
            r_key_event <= w_accept;
            if (i_key_valid) begin
                r_cand      <= i_key_code;
                r_rel_cnt   <= '0;
                r_press_cnt <= w_press_nxt;
                if (w_accept) begin
                    r_armed    <= 1'b0;
                    r_key_last <= i_key_code;
                end
            end else begin
                r_rel_cnt <= w_rel_nxt;
                if (w_rel_nxt == REL_MAX) begin
                    r_armed     <= 1'b1;
                    r_press_cnt <= '0;
                end
            end
        end
    end

    assign w_digit    = {3'b000, r_key_last};
    assign w_is_digit = (r_key_last <= 4'd9);
    assign w_room     = (r_digits < DIG_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ENTER_A;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
            r_digits <= '0;
        end else if (r_key_event) begin
            if (w_is_digit) begin
                case (r_state)
                    ENTER_A: if (w_room) begin
                        r_op_a   <= r_op_a * 7'd10 + w_digit;
                        r_digits <= r_digits + 2'd1;
                    end
                    ENTER_B: if (w_room) begin
                        r_op_b   <= r_op_b * 7'd10 + w_digit;
                        r_digits <= r_digits + 2'd1;
                    end
                    default: begin
                        r_op_a   <= w_digit;
                        r_op_b   <= '0;
                        r_digits <= 2'd1;
                        r_state  <= ENTER_A;
                    end
                endcase
            end else if (r_key_last == 4'd12) begin
                case (r_state)
                    ENTER_A: begin
                        r_state  <= ENTER_B;
                        r_digits <= '0;
                    end
                    ENTER_B: begin
                        r_result <= {1'b0, r_op_a} + {1'b0, r_op_b};
                        r_state  <= SHOW_SUM;
                    end
                    default: ;
                endcase
            end else if (r_key_last == 4'd11) begin
                r_op_a   <= '0;
                r_op_b   <= '0;
                r_result <= '0;
                r_digits <= '0;
                r_state  <= ENTER_A;
            end
        end
    end

    always_comb begin
        case (r_state)
            ENTER_A: w_show = {1'b0, r_op_a};
            ENTER_B: w_show = {1'b0, r_op_b};
            default: w_show = r_result;
        endcase
        w_hund = 4'(w_show / 8'd100);
        w_tens = 4'((w_show / 8'd10) % 8'd10);
        w_unit = 4'(w_show % 8'd10);
    end

    // Leading zeros blank; the units digit is always shown.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_disp <= 16'hFFF0;
        else
            r_disp <= {4'hF,
                       (w_hund == 4'd0) ? 4'hF : w_hund,
                       ((w_hund == 4'd0) && (w_tens == 4'd0)) ? 4'hF : w_tens,
                       w_unit};
    end

    assign o_key_event = r_key_event;
    assign o_key_last  = r_key_last;
    assign o_state     = r_state;
    assign o_operand_a = r_op_a;
    assign o_operand_b = r_op_b;
    assign o_result    = r_result;
    assign o_disp_bcd  = r_disp;
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Scoreboard bench for keypad_entry_ctrl: stimulus pushes the reference model's expected state per press,
// a monitor pops on every key_event and checks key_last, the FSM outputs and the display word.
module tb_keypad_entry_ctrl;
    localparam int DEB  = 4;
    localparam int REL  = 8;
    localparam int MAXD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  kc;
    logic        kv;
    logic        key_event;
    logic [3:0]  key_last;
    logic [1:0]  state;
    logic [6:0]  op_a;
    logic [6:0]  op_b;
    logic [7:0]  result;
    logic [15:0] disp;

    keypad_entry_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .RELEASE_CYCLES (REL),
        .MAX_DIGITS     (MAXD)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_key_code (kc),
        .i_key_valid(kv),
        .o_key_event(key_event),
        .o_key_last (key_last),
        .o_state    (state),
        .o_operand_a(op_a),
        .o_operand_b(op_b),
        .o_result   (result),
        .o_disp_bcd (disp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  key;
        logic [1:0]  st;
        logic [6:0]  a;
        logic [6:0]  b;
        logic [7:0]  res;
        logic [15:0] disp;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: calculator state as plain integers.
    int m_state, m_a, m_b, m_res, m_cnt;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Display word built from the decimal text of the value, right-aligned, blanks elsewhere.
    function automatic logic [15:0] disp_of(input int v);
        string       s;
        logic [15:0] d;
        s = $sformatf("%0d", v);
        d = 16'hFFFF;
        for (int i = 0; i < s.len(); i++) begin
            int pos;
            pos = s.len() - 1 - i;
            d[pos*4 +: 4] = 4'(int'(s[i]) - 48);
        end
        return d;
    endfunction

    task automatic model_reset();
        m_state = 0; m_a = 0; m_b = 0; m_res = 0; m_cnt = 0;
    endtask

    task automatic push_key(input int k);
        exp_t e;
        int   shown;
        if (k <= 9) begin
            if (m_state == 2) begin
                m_a = k; m_b = 0; m_cnt = 1; m_state = 0;
            end else if (m_cnt < MAXD) begin
                if (m_state == 0) m_a = m_a * 10 + k;
                else              m_b = m_b * 10 + k;
                m_cnt++;
            end
        end else if (k == 12) begin
            if (m_state == 0) begin
                m_state = 1; m_cnt = 0;
            end else if (m_state == 1) begin
                m_res = m_a + m_b; m_state = 2;
            end
        end else if (k == 11) begin
            m_a = 0; m_b = 0; m_res = 0; m_cnt = 0; m_state = 0;
        end
        shown  = (m_state == 0) ? m_a : (m_state == 1) ? m_b : m_res;
        e.key  = 4'(k);
        e.st   = 2'(m_state);
        e.a    = 7'(m_a);
        e.b    = 7'(m_b);
        e.res  = 8'(m_res);
        e.disp = disp_of(shown);
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input int n);
        kv = v;
        kc = v ? c : 4'hF;
        repeat (n) tick();
    endtask

    task automatic tap(input int k);
        push_key(k);
        drive(1'b1, 4'(k), 6);
        drive(1'b0, 4'hF, 10);
    endtask

    task automatic tap_rand(input int k);
        push_key(k);
        drive(1'b1, 4'(k), $urandom_range(DEB, DEB + 4));
        drive(1'b0, 4'hF, $urandom_range(REL, REL + 4));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_event"}, 16'(key_event), 16'h0);
        check({tag, "_last"},  16'(key_last),  16'hF);
        check({tag, "_state"}, 16'(state),     16'h0);
        check({tag, "_a"},     16'(op_a),      16'h0);
        check({tag, "_b"},     16'(op_b),      16'h0);
        check({tag, "_res"},   16'(result),    16'h0);
        check({tag, "_disp"},  disp,           16'hFFF0);
    endtask

    // Monitor: every key_event consumes one expected press.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (key_event === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: got key %0h expected no event", key_last);
                end else begin
                    e = sb_q.pop_front();
                    check("key_last", 16'(key_last), 16'(e.key));
                    @(negedge clk);
                    check("state",     16'(state),  16'(e.st));
                    check("operand_a", 16'(op_a),   16'(e.a));
                    check("operand_b", 16'(op_b),   16'(e.b));
                    check("result",    16'(result), 16'(e.res));
                    @(negedge clk);
                    check("disp_bcd",  disp,        e.disp);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq1 [6] = '{4, 5, 12, 3, 7, 12};
        int seq2 [6] = '{9, 9, 12, 9, 9, 12};
        int seq3 [8] = '{9, 9, 9, 12, 9, 9, 9, 12};
        int seq4 [5] = '{1, 2, 12, 3, 11};
        int seq5 [9] = '{10, 13, 14, 2, 12, 3, 12, 12, 7};

        rst = 1'b1;
        kv  = 1'b0;
        kc  = 4'hF;
        model_reset();
        repeat (3) tick();
        check_reset("reset");
        rst = 1'b0;
        tick();

        foreach (seq1[i]) tap(seq1[i]);
        tap(11);
        foreach (seq2[i]) tap(seq2[i]);
        tap(11);
        foreach (seq3[i]) tap(seq3[i]);
        tap(11);
        foreach (seq4[i]) tap(seq4[i]);
        foreach (seq5[i]) tap(seq5[i]);

        // Held key with scanner-style valid gaps shorter than the release window.
        tap(11);
        push_key(3);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 4'd3, 1);
            drive(1'b0, 4'hF, 1);
        end
        drive(1'b0, 4'hF, 10);

        // Bouncing code never settles, then settles on 6.
        tap(11);
        for (int i = 0; i < 10; i++)
            drive(1'b1, (i % 2 == 1) ? 4'd2 : 4'd6, 1);
        push_key(6);
        drive(1'b1, 4'd6, 4);
        drive(1'b0, 4'hF, 10);

        repeat (40) tap_rand($urandom_range(0, 14));

        // Reset in the middle of a press count.
        tap(11);
        drive(1'b1, 4'd8, 2);
        rst = 1'b1;
        tick();
        check_reset("midrst");
        rst = 1'b0;
        model_reset();
        drive(1'b1, 4'd8, 3);
        check("rearm_no_early_event_a", 16'(op_a), 16'h0);
        push_key(8);
        drive(1'b1, 4'd8, 1);
        drive(1'b0, 4'hF, 10);

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_events: got %0d outstanding expected 0", sb_q.size());
        end
        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
